// File: rtl/hit_score_counter_if.sv
// hit_score_counter_if: control, hit inputs and score/display outputs of the score counter
interface hit_score_counter_if #(
    parameter int N_CH    = 3,
    parameter int SCORE_W = 8
);
    logic               enable;
    logic               clear;
    logic [N_CH-1:0]    hit_in;
    logic [SCORE_W-1:0] score;
    logic [3:0]         score_ones;
    logic [3:0]         score_tens;
    logic               sample_tick;
    logic               hit_pulse;
    logic               game_over;

    modport master (
        output enable, clear, hit_in,
        input  score, score_ones, score_tens, sample_tick, hit_pulse, game_over
    );

    modport slave (
        input  enable, clear, hit_in,
        output score, score_ones, score_tens, sample_tick, hit_pulse, game_over
    );
endinterface

// File: rtl/hit_score_counter.sv
// hit_score_counter: tick-sampled multi-channel hit scorer with saturating BCD score and game-over
module hit_score_counter #(
    parameter int N_CH       = 3,
    parameter int SAMPLE_DIV = 2000000,
    parameter int SCORE_W    = 8,
    parameter int MAX_SCORE  = 99,
    parameter int COUNT_MODE = 0,
    parameter int EDGE_MODE  = 1
) (
    input logic               clock,
    input logic               reset,
    hit_score_counter_if.slave bus
);
    localparam int SW = SCORE_W + 4;
    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic {RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    hit_m_q, hit_s_q, prev_q, prev_d, hits;
    logic [CW-1:0]      samp_q, samp_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         ones_q, ones_d, tens_q, tens_d, tens;
    logic               tick_q, tick_d, pulse_q, pulse_d, tick;
    logic [SW-1:0]      pop, inc, sum, sat;

    assign tick = samp_q == CW'(SAMPLE_DIV - 1) && bus.enable && state_q == RUN;
    assign hits = EDGE_MODE != 0 ? hit_s_q & ~prev_q : hit_s_q;
    assign inc  = COUNT_MODE != 0 ? pop : SW'(|hits);
    assign sum  = SW'(score_q) + inc;
    assign sat  = sum >= SW'(MAX_SCORE) ? SW'(MAX_SCORE) : sum;
    // sat never exceeds 99, where x*205>>11 equals x/10
    assign tens = 4'((16'(sat) * 16'd205) >> 11);

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++)
            pop = pop + SW'(hits[i]);
    end

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        prev_d  = prev_q;
        score_d = score_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        tick_d  = 1'b0;
        pulse_d = 1'b0;
        if (bus.clear) begin
            state_d = RUN;
            samp_d  = '0;
            prev_d  = '0;
            score_d = '0;
            ones_d  = '0;
            tens_d  = '0;
        end else if (state_q == RUN && bus.enable) begin
            samp_d = tick ? '0 : samp_q + CW'(1);
            if (tick) begin
                prev_d  = hit_s_q;
                score_d = SCORE_W'(sat);
                tens_d  = tens;
                ones_d  = 4'(16'(sat) - 16'(tens) * 16'd10);
                tick_d  = 1'b1;
                pulse_d = inc != '0;
                state_d = sat == SW'(MAX_SCORE) ? DONE : RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            hit_m_q <= '0;
            hit_s_q <= '0;
            samp_q  <= '0;
            prev_q  <= '0;
            score_q <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            tick_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_m_q <= bus.hit_in;
            hit_s_q <= hit_m_q;
            samp_q  <= samp_d;
            prev_q  <= prev_d;
            score_q <= score_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.score       = score_q;
    assign bus.score_ones  = ones_q;
    assign bus.score_tens  = tens_q;
    assign bus.sample_tick = tick_q;
    assign bus.hit_pulse   = pulse_q;
    assign bus.game_over   = state_q == DONE;
endmodule

// File: tb/tb_hit_score_counter.sv
// tb_hit_score_counter: scoreboard bench over three parameterisations (edge/any, edge/popcount, level/any)
module tb_hit_score_counter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hit_score_counter_if #(.N_CH(3), .SCORE_W(8)) ia ();
    hit_score_counter_if #(.N_CH(3), .SCORE_W(8)) ib ();
    hit_score_counter_if #(.N_CH(3), .SCORE_W(8)) ic ();

    hit_score_counter #(.N_CH(3), .SAMPLE_DIV(4), .SCORE_W(8), .MAX_SCORE(99), .COUNT_MODE(0), .EDGE_MODE(1))
        ua (.clock(clock), .reset(reset), .bus(ia));
    hit_score_counter #(.N_CH(3), .SAMPLE_DIV(4), .SCORE_W(8), .MAX_SCORE(99), .COUNT_MODE(1), .EDGE_MODE(1))
        ub (.clock(clock), .reset(reset), .bus(ib));
    hit_score_counter #(.N_CH(3), .SAMPLE_DIV(4), .SCORE_W(8), .MAX_SCORE(99), .COUNT_MODE(0), .EDGE_MODE(0))
        uc (.clock(clock), .reset(reset), .bus(ic));

    logic [2:0] tk, hp, go;
    logic [7:0] sc [3];
    logic [3:0] on [3];
    logic [3:0] tn [3];

    assign tk = {ic.sample_tick, ib.sample_tick, ia.sample_tick};
    assign hp = {ic.hit_pulse, ib.hit_pulse, ia.hit_pulse};
    assign go = {ic.game_over, ib.game_over, ia.game_over};
    assign sc[0] = ia.score;
    assign sc[1] = ib.score;
    assign sc[2] = ic.score;
    assign on[0] = ia.score_ones;
    assign on[1] = ib.score_ones;
    assign on[2] = ic.score_ones;
    assign tn[0] = ia.score_tens;
    assign tn[1] = ib.score_tens;
    assign tn[2] = ic.score_tens;

    typedef struct {
        int   u;
        int   s;
        logic p;
        logic g;
        int   n;
    } exp_t;

    exp_t sb[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_tick(int u, int s, logic p, logic g, int n);
        exp_t e;
        int   k;
        sb.push_back('{u, s, p, g, n});
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (k < 40 && !tk[u]);
        e = sb.pop_front();
        if (!tk[e.u]) begin
            check("tick_timeout", 0, 1);
        end else begin
            check("tick_wait", k, e.n);
            check("score", sc[e.u], e.s);
            check("ones", on[e.u], e.s % 10);
            check("tens", tn[e.u], e.s / 10);
            check("hit_pulse", hp[e.u], e.p);
            check("game_over", go[e.u], e.g);
        end
    endtask

    task automatic check_zero(string tag, int u);
        check({tag, "_score"}, sc[u], 0);
        check({tag, "_ones"}, on[u], 0);
        check({tag, "_tens"}, tn[u], 0);
        check({tag, "_tick"}, tk[u], 0);
        check({tag, "_pulse"}, hp[u], 0);
        check({tag, "_go"}, go[u], 0);
    endtask

    initial begin
        int       exp_s;
        int       cnt;
        logic [2:0] pat;
        ia.enable = 0; ia.clear = 0; ia.hit_in = '0;
        ib.enable = 0; ib.clear = 0; ib.hit_in = '0;
        ic.enable = 0; ic.clear = 0; ic.hit_in = '0;
        repeat (3) @(negedge clock);
        check_zero("reset", 0);
        check_zero("reset", 1);

        reset = 0;
        ia.enable = 1;
        ia.hit_in = 3'b001;
        expect_tick(0, 1, 1, 0, 4);
        expect_tick(0, 1, 0, 0, 4);
        expect_tick(0, 1, 0, 0, 4);
        ia.hit_in = '0;
        repeat (2) @(negedge clock);
        ia.enable = 0;
        repeat (10) @(negedge clock);
        ia.enable = 1;
        expect_tick(0, 1, 0, 0, 2);

        ia.hit_in = 3'b001;
        repeat (3) @(negedge clock);
        ia.clear = 1;
        @(negedge clock);
        ia.clear = 0;
        check("clear_score", sc[0], 0);
        check("clear_tick", tk[0], 0);
        check("clear_pulse", hp[0], 0);
        expect_tick(0, 1, 1, 0, 4);
        ia.enable = 0;
        ia.hit_in = '0;

        ib.enable = 1;
        expect_tick(1, 0, 0, 0, 4);
        exp_s = 0;
        while (exp_s < 98) begin
            pat = (exp_s + 3 <= 98) ? 3'b111 : 3'b001;
            ib.hit_in = pat;
            exp_s += (pat == 3'b111) ? 3 : 1;
            expect_tick(1, exp_s, 1, 0, 4);
            ib.hit_in = '0;
            expect_tick(1, exp_s, 0, 0, 4);
        end
        ib.hit_in = 3'b111;
        expect_tick(1, 99, 1, 1, 4);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            ib.hit_in = (i % 8 < 4) ? 3'b000 : 3'b111;
            @(negedge clock);
            cnt += int'(tk[1]);
        end
        check("done_ticks", cnt, 0);
        check("done_score", sc[1], 99);
        check("done_go", go[1], 1);
        ib.clear = 1;
        @(negedge clock);
        ib.clear = 0;
        ib.enable = 0;
        check("done_clear_score", sc[1], 0);
        check("done_clear_go", go[1], 0);

        ic.enable = 1;
        ic.hit_in = 3'b010;
        for (int k = 1; k <= 5; k++)
            expect_tick(2, k, 1, 0, 4);
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
        check_zero("midreset", 2);
        reset = 0;
        expect_tick(2, 1, 1, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
